// File: rtl/param_fifo.sv
// Single-clock FIFO with configurable width and depth, occupancy count, almost-full/empty
// thresholds, standard or first-word-fall-through read, and rejected-request error pulses.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  push_err_on_full,
  output logic                  pop_err_on_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  push_ok;
  logic                  pop_ok;

  // Request semantics: push/pop are one-cycle requests with no backpressure handshake.
  // A push is taken unless full (a same-cycle pop frees the slot); a pop is taken unless empty.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // In FWFT mode the head word is shown live; dout_q keeps the last shown word for when empty.
  assign data_out = (FWFT && !empty) ? mem[rp] : dout_q;

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp               <= '0;
      rp               <= '0;
      count            <= '0;
      dout_q           <= '0;
      push_err_on_full <= 1'b0;
      pop_err_on_empty <= 1'b0;
    end else begin
      push_err_on_full <= push & full & ~pop;
      pop_err_on_empty <= pop & empty;

      if (push_ok) begin
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (pop_ok) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (FWFT) begin
        if (!empty) dout_q <= mem[rp];
      end else if (pop_ok) begin
        dout_q <= mem[rp];
      end
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: a DEPTH=16 standard-read instance, a DEPTH=5 wrap instance
// and a DEPTH=4 FWFT instance, all sharing clock and reset.
module tb_param_fifo;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;

  // Instance A: DEPTH=16, AF=14, AE=2, standard read
  logic       a_push, a_pop;
  logic [7:0] a_din, a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_perr, a_uerr;
  logic [4:0] a_count;

  // Instance B: DEPTH=5, AF=4, AE=1, standard read
  logic       b_push, b_pop;
  logic [7:0] b_din, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_perr, b_uerr;
  logic [2:0] b_count;

  // Instance C: DEPTH=4, FWFT
  logic       c_push, c_pop;
  logic [7:0] c_din, c_dout;
  logic       c_empty, c_full, c_ae, c_af, c_perr, c_uerr;
  logic [2:0] c_count;

  param_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .data_in(a_din), .pop(a_pop), .data_out(a_dout),
    .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .push_err_on_full(a_perr), .pop_err_on_empty(a_uerr));

  param_fifo #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b0)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .data_in(b_din), .pop(b_pop), .data_out(b_dout),
    .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .push_err_on_full(b_perr), .pop_err_on_empty(b_uerr));

  param_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b1)) u_c (
    .clk(clk), .rst(rst), .push(c_push), .data_in(c_din), .pop(c_pop), .data_out(c_dout),
    .empty(c_empty), .full(c_full), .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
    .push_err_on_full(c_perr), .pop_err_on_empty(c_uerr));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_push = 0; a_pop = 0; a_din = 0;
    b_push = 0; b_pop = 0; b_din = 0;
    c_push = 0; c_pop = 0; c_din = 0;
    step();
    step();
    rst = 1'b0;
    chk_cnt++; if (a_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", a_empty); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b0) $display("FAIL rst_full got %b want 0", a_full); else pass_cnt++;
    chk_cnt++; if (a_count !== 5'd0) $display("FAIL rst_count got %0d want 0", a_count); else pass_cnt++;
    chk_cnt++; if (a_ae !== 1'b1) $display("FAIL rst_ae got %b want 1", a_ae); else pass_cnt++;
    chk_cnt++; if (a_af !== 1'b0) $display("FAIL rst_af got %b want 0", a_af); else pass_cnt++;
    chk_cnt++; if (a_dout !== 8'h00) $display("FAIL rst_dout got %h want 00", a_dout); else pass_cnt++;
    chk_cnt++; if (a_perr !== 1'b0 || a_uerr !== 1'b0) $display("FAIL rst_errs got %b%b want 00", a_perr, a_uerr); else pass_cnt++;
    chk_cnt++; if (c_dout !== 8'h00) $display("FAIL rst_fwft_dout got %h want 00", c_dout); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      a_push = 1; a_din = 8'(i);
      step();
      chk_cnt++; if (a_count !== 5'(i + 1)) $display("FAIL fill_count got %0d want %0d", a_count, i + 1); else pass_cnt++;
      chk_cnt++; if (a_af !== (i + 1 >= 14)) $display("FAIL fill_af at %0d got %b", i + 1, a_af); else pass_cnt++;
      chk_cnt++; if (a_ae !== (i + 1 <= 2)) $display("FAIL fill_ae at %0d got %b", i + 1, a_ae); else pass_cnt++;
      chk_cnt++; if (a_full !== (i + 1 == 16)) $display("FAIL fill_full at %0d got %b", i + 1, a_full); else pass_cnt++;
    end
    // Overflow: push without pop while full
    a_din = 8'hAA;
    step();
    a_push = 0;
    chk_cnt++; if (a_perr !== 1'b1) $display("FAIL ovf_err got %b want 1", a_perr); else pass_cnt++;
    chk_cnt++; if (a_count !== 5'd16) $display("FAIL ovf_count got %0d want 16", a_count); else pass_cnt++;
    step();
    chk_cnt++; if (a_perr !== 1'b0) $display("FAIL ovf_err_clear got %b want 0", a_perr); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      a_pop = 1;
      step();
      chk_cnt++; if (a_dout !== 8'(i)) $display("FAIL drain_data got %h want %h", a_dout, 8'(i)); else pass_cnt++;
      chk_cnt++; if (a_count !== 5'(15 - i)) $display("FAIL drain_count got %0d want %0d", a_count, 15 - i); else pass_cnt++;
    end
    chk_cnt++; if (a_empty !== 1'b1) $display("FAIL drain_empty got %b want 1", a_empty); else pass_cnt++;
    // Underflow: pop while empty
    step();
    a_pop = 0;
    chk_cnt++; if (a_uerr !== 1'b1) $display("FAIL udf_err got %b want 1", a_uerr); else pass_cnt++;
    chk_cnt++; if (a_dout !== 8'h0F) $display("FAIL udf_dout got %h want 0f", a_dout); else pass_cnt++;
    step();
    chk_cnt++; if (a_uerr !== 1'b0) $display("FAIL udf_err_clear got %b want 0", a_uerr); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      a_push = 1; a_din = 8'(8'h20 + i);
      step();
    end
    a_pop = 1; a_din = 8'h99;
    step();
    a_push = 0;
    chk_cnt++; if (a_count !== 5'd16) $display("FAIL simfull_count got %0d want 16", a_count); else pass_cnt++;
    chk_cnt++; if (a_perr !== 1'b0) $display("FAIL simfull_err got %b want 0", a_perr); else pass_cnt++;
    chk_cnt++; if (a_dout !== 8'h20) $display("FAIL simfull_dout got %h want 20", a_dout); else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk_cnt++;
      if (a_dout !== ((i == 16) ? 8'h99 : 8'(8'h20 + i)))
        $display("FAIL simfull_drain got %h at %0d", a_dout, i);
      else pass_cnt++;
    end
    a_push = 1; a_din = 8'h77;
    step();
    a_push = 0;
    chk_cnt++; if (a_count !== 5'd1) $display("FAIL simempty_count got %0d want 1", a_count); else pass_cnt++;
    chk_cnt++; if (a_uerr !== 1'b1) $display("FAIL simempty_err got %b want 1", a_uerr); else pass_cnt++;
    chk_cnt++; if (a_dout !== 8'h99) $display("FAIL simempty_dout got %h want 99", a_dout); else pass_cnt++;
    step();
    a_pop = 0;
    chk_cnt++; if (a_dout !== 8'h77) $display("FAIL simempty_read got %h want 77", a_dout); else pass_cnt++;
    chk_cnt++; if (a_count !== 5'd0 || a_uerr !== 1'b0) $display("FAIL simempty_after got cnt %0d err %b want 0 0", a_count, a_uerr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    // Scoreboard: expected queue plus model count
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;
    int         cnt;
    int         op;
    logic [7:0] val;
    cnt = 0;
    val = 8'h40;
    exp_d = 8'h00;
    // 4 pushes, 3 pops, 16 push+pop, 1 pop: 20 pushes wrap both pointers several times
    for (int k = 0; k < 24; k++) begin
      op = (k < 4) ? 1 : (k < 7) ? 2 : (k < 23) ? 3 : 2;
      b_push = op[0]; b_pop = op[1]; b_din = val;
      step();
      if (op[1]) begin
        exp_d = exp_q.pop_front();
        cnt--;
      end
      if (op[0]) begin
        exp_q.push_back(val);
        val++;
        cnt++;
      end
      chk_cnt++; if (b_count !== 3'(cnt)) $display("FAIL wrap_count got %0d want %0d", b_count, cnt); else pass_cnt++;
      chk_cnt++; if (b_af !== (cnt >= 4)) $display("FAIL wrap_af at %0d got %b", cnt, b_af); else pass_cnt++;
      chk_cnt++; if (b_ae !== (cnt <= 1)) $display("FAIL wrap_ae at %0d got %b", cnt, b_ae); else pass_cnt++;
      if (op[1]) begin
        chk_cnt++; if (b_dout !== exp_d) $display("FAIL wrap_data got %h want %h", b_dout, exp_d); else pass_cnt++;
      end
    end
    b_push = 0; b_pop = 0;
    chk_cnt++; if (b_empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", b_empty); else pass_cnt++;
  endtask

  task automatic test_fwft();
    c_push = 1; c_din = 8'h5A;
    step();
    chk_cnt++; if (c_dout !== 8'h5A) $display("FAIL fwft_show got %h want 5a", c_dout); else pass_cnt++;
    chk_cnt++; if (c_empty !== 1'b0) $display("FAIL fwft_empty got %b want 0", c_empty); else pass_cnt++;
    c_din = 8'h6B;
    step();
    c_push = 0;
    chk_cnt++; if (c_dout !== 8'h5A) $display("FAIL fwft_hold got %h want 5a", c_dout); else pass_cnt++;
    c_pop = 1;
    step();
    chk_cnt++; if (c_dout !== 8'h6B) $display("FAIL fwft_next got %h want 6b", c_dout); else pass_cnt++;
    step();
    chk_cnt++; if (c_empty !== 1'b1) $display("FAIL fwft_drained got %b want 1", c_empty); else pass_cnt++;
    chk_cnt++; if (c_dout !== 8'h6B) $display("FAIL fwft_last got %h want 6b", c_dout); else pass_cnt++;
    step();
    c_pop = 0;
    chk_cnt++; if (c_uerr !== 1'b1) $display("FAIL fwft_udf got %b want 1", c_uerr); else pass_cnt++;
    chk_cnt++; if (c_dout !== 8'h6B) $display("FAIL fwft_udf_dout got %h want 6b", c_dout); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      a_push = 1; a_din = 8'(8'h10 + i);
      step();
    end
    a_pop = 1;
    step();
    chk_cnt++; if (a_dout !== 8'h10) $display("FAIL mid_pre_dout got %h want 10", a_dout); else pass_cnt++;
    chk_cnt++; if (a_count !== 5'd7) $display("FAIL mid_pre_count got %0d want 7", a_count); else pass_cnt++;
    rst = 1;
    step();
    rst = 0; a_pop = 0; a_din = 8'h33;
    chk_cnt++; if (a_count !== 5'd0) $display("FAIL mid_count got %0d want 0", a_count); else pass_cnt++;
    chk_cnt++; if (a_empty !== 1'b1) $display("FAIL mid_empty got %b want 1", a_empty); else pass_cnt++;
    chk_cnt++; if (a_dout !== 8'h00) $display("FAIL mid_dout got %h want 00", a_dout); else pass_cnt++;
    chk_cnt++; if (a_perr !== 1'b0 || a_uerr !== 1'b0) $display("FAIL mid_errs got %b%b want 00", a_perr, a_uerr); else pass_cnt++;
    step();
    a_push = 0; a_pop = 1;
    chk_cnt++; if (a_count !== 5'd1) $display("FAIL mid_push_count got %0d want 1", a_count); else pass_cnt++;
    step();
    a_pop = 0;
    chk_cnt++; if (a_dout !== 8'h33) $display("FAIL mid_read got %h want 33", a_dout); else pass_cnt++;
    chk_cnt++; if (a_empty !== 1'b1) $display("FAIL mid_read_empty got %b want 1", a_empty); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
